// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction geometry and opcode encodings used by
// the fetch unit, the control unit and the fetch bench.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int OPC_LSB = INSTR_W - OPC_W;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_LT   = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SHL  = 4'd5,
        OP_ST   = 4'd6,
        OP_LD   = 4'd7,
        OP_SLI  = 4'd8,
        OP_BR   = 4'd9,
        OP_JUMP = 4'd10
    } opcode_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush; the head is read
// straight out of storage so the consumer sees it in the cycle it becomes valid.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues synchronous imem reads, buffers responses
// and hands instructions to decode over valid/ready; redirects flush the stage.
module instr_fetch_unit #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]        imem_rdata,
    output logic [INSTR_W-1:0]        instr,
    output logic [cpu_pkg::OPC_W-1:0] opcode,
    output logic [PC_W-1:0]           instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      redirect_valid,
    input  logic [PC_W-1:0]           redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = PC_W + INSTR_W;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q;
    logic             inflight_q;
    logic             issue, pop, fifo_pop, fifo_push, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ, lim;
    logic [ENT_W-1:0] head;

    assign pop       = instr_valid && instr_ready;
    assign fifo_pop  = pop && !redirect_valid;
    // The only response that can be in flight during a redirect arrives in
    // that same cycle, so killing it is simply suppressing its push.
    assign fifo_push = inflight_q && !redirect_valid;

    // Issue only if the returning word is guaranteed a FIFO slot.
    assign occ   = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
    assign lim   = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop);
    assign issue = (occ < lim) && !redirect_valid;

    assign imem_req  = issue && rst_n;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (issue)     pc_d = pc_q + PC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) req_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({req_pc_q, imem_rdata}),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head[INSTR_W-1:0];
    assign instr_pc    = head[ENT_W-1:INSTR_W];
    assign opcode      = instr[INSTR_W-1 -: cpu_pkg::OPC_W];

endmodule
